// File: rtl/alu_pkg.sv
// Shared types for the ALU issuing controller: ALU funct codes,
// request op codes and controller states.
package alu_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [2:0] {
        F_LOAD = 3'd0,
        F_SUM  = 3'd1,
        F_SUB  = 3'd2,
        F_AND  = 3'd3,
        F_XOR  = 3'd4,
        F_NOT  = 3'd5,
        F_INC  = 3'd6
    } alu_funct_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_XOR = 4'd3,
        OP_OR  = 4'd4,
        OP_SLT = 4'd5,
        OP_BEQ = 4'd6,
        OP_BNE = 4'd7,
        OP_BLT = 4'd8,
        OP_BGE = 4'd9,
        OP_NOT = 4'd10,
        OP_INC = 4'd11,
        OP_MOV = 4'd12
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_RESP = 3'd4
    } ctrl_state_t;

    // Ops above MOV have no meaning and never reach the ALU.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'd12;
    endfunction

endpackage

// File: rtl/alu_op_map.sv
// Combinational table: request op + controller state -> ALU funct,
// operand select and multi-pass indication.
module alu_op_map
    import alu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  ctrl_state_t i_state,
    output alu_funct_t  o_funct,
    output logic        o_sel_tmp,
    output logic        o_multi,
    output logic        o_legal
);

    // Pick the ALU function for the pass the controller is in.
    always_comb begin
        o_funct   = F_LOAD;
        o_sel_tmp = 1'b0;
        o_legal   = op_legal(i_op);
        o_multi   = (i_op == OP_OR);
        case (i_state)
            S_P1: begin
                case (i_op)
                    OP_ADD:  o_funct = F_SUM;
                    OP_SUB:  o_funct = F_SUB;
                    OP_SLT:  o_funct = F_SUB;
                    OP_BEQ:  o_funct = F_SUB;
                    OP_BNE:  o_funct = F_SUB;
                    OP_BLT:  o_funct = F_SUB;
                    OP_BGE:  o_funct = F_SUB;
                    OP_AND:  o_funct = F_AND;
                    OP_OR:   o_funct = F_AND;
                    OP_XOR:  o_funct = F_XOR;
                    OP_NOT:  o_funct = F_NOT;
                    OP_INC:  o_funct = F_INC;
                    default: o_funct = F_LOAD;
                endcase
            end
            S_P2: o_funct = F_XOR;
            S_P3: begin
                o_funct   = F_XOR;
                o_sel_tmp = 1'b1;
            end
            default: o_funct = F_LOAD;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU issuing controller: one request in, one or three
// ALU passes, one registered response out. Optional macro ALU_ERR_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic [2:0]      alu_funct,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_overflow,
    input  logic            alu_equal,
    input  logic            alu_less,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_taken,
    output logic            rsp_overflow
`ifdef ALU_ERR_EN
    ,
    output logic            rsp_error
`endif
);

    ctrl_state_t     r_state;
    ctrl_state_t     w_next;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_tmp;
    logic [XLEN-1:0] r_res;
    logic            r_taken;
    logic            r_ovf;

    alu_funct_t      w_funct;
    logic            w_sel_tmp;
    logic            w_multi;
    logic            w_legal;
    logic [XLEN-1:0] w_res;
    logic            w_taken;
    logic            w_ovf;

    alu_op_map u_map (
        .i_op      (r_op),
        .i_state   (r_state),
        .o_funct   (w_funct),
        .o_sel_tmp (w_sel_tmp),
        .o_multi   (w_multi),
        .o_legal   (w_legal)
    );

    // ALU drive: the final OR pass combines the partial result and tmp.
    always_comb begin
        alu_funct = w_funct;
        alu_a     = w_sel_tmp ? r_res : r_a;
        alu_b     = w_sel_tmp ? r_tmp : r_b;
    end

    // Single-pass response fields derived from the ALU result and flags.
    always_comb begin
        w_res   = alu_result;
        w_taken = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            OP_ADD:  w_ovf = alu_overflow;
            OP_SUB:  w_ovf = alu_overflow;
            OP_SLT:  w_res = {{(XLEN-1){1'b0}}, alu_less};
            OP_BEQ: begin
                w_res   = '0;
                w_taken = alu_equal;
            end
            OP_BNE: begin
                w_res   = '0;
                w_taken = ~alu_equal;
            end
            OP_BLT: begin
                w_res   = '0;
                w_taken = alu_less;
            end
            OP_BGE: begin
                w_res   = '0;
                w_taken = ~alu_less;
            end
            default: begin
                if (!w_legal) begin
                    w_res = '0;
                end
            end
        endcase
    end

    // Next-state sequencing of the passes and response handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = S_P1;
            S_P1:   w_next = w_multi ? S_P2 : S_RESP;
            S_P2:   w_next = S_P3;
            S_P3:   w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch and per-pass result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_tmp   <= '0;
            r_res   <= '0;
            r_taken <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op <= req_op;
                        r_a  <= req_a;
                        r_b  <= req_b;
                    end
                end
                S_P1: begin
                    if (w_multi) begin
                        r_tmp <= alu_result;
                    end else begin
                        r_res   <= w_res;
                        r_taken <= w_taken;
                        r_ovf   <= w_ovf;
                    end
                end
                S_P2: r_res <= alu_result;
                S_P3: begin
                    r_res   <= alu_result;
                    r_taken <= 1'b0;
                    r_ovf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ERR_EN
    logic r_err;

    // Error flag: illegal op, or ADD/SUB that overflowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (r_state == S_P1) begin
            r_err <= !w_legal || w_ovf;
        end else if (r_state == S_P3) begin
            r_err <= 1'b0;
        end
    end

    assign rsp_error = r_err;
`endif

    assign req_ready    = (r_state == S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_result   = r_res;
    assign rsp_taken    = r_taken;
    assign rsp_overflow = r_ovf;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl with a behavioural
// 64-bit ALU model closing the loop.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [2:0]  alu_funct;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic        alu_overflow;
    logic        alu_equal;
    logic        alu_less;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_taken;
    logic        rsp_overflow;
`ifdef ALU_ERR_EN
    logic        rsp_error;
`endif

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic        taken;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   ncomp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.XLEN(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_funct    (alu_funct),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_equal    (alu_equal),
        .alu_less     (alu_less),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_taken    (rsp_taken),
        .rsp_overflow (rsp_overflow)
`ifdef ALU_ERR_EN
        ,
        .rsp_error    (rsp_error)
`endif
    );

    // Behavioural ALU.
    always_comb begin
        alu_result   = alu_a;
        alu_overflow = 1'b0;
        case (alu_funct)
            3'd1: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[63] == alu_b[63])
                            && (alu_result[63] != alu_a[63]);
            end
            3'd2: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[63] != alu_b[63])
                            && (alu_result[63] != alu_a[63]);
            end
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: alu_result = alu_a + 64'd1;
            default: alu_result = alu_a;
        endcase
        alu_equal = (alu_a == alu_b);
        alu_less  = ($signed(alu_a) < $signed(alu_b));
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic mk(input string tag, input logic [63:0] res,
                      input logic tk, input logic ov, input logic er,
                      output exp_t e);
        e.tag   = tag;
        e.res   = res;
        e.taken = tk;
        e.ovf   = ov;
        e.err   = er;
    endtask

    // Issue one op, check pass functs and latency, hold, then drain.
    task automatic do_op(input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input int lat_exp, input int npass,
                         input logic [8:0] fseq, input int hold,
                         input exp_t e);
        exp_t g;
        int   lat;
        int   k;
        bit   got;
        exp_q.push_back(e);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        k   = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (k < npass) begin
                    chk({e.tag, "_funct"}, 64'(alu_funct),
                        64'(fseq[k*3 +: 3]));
                    k++;
                end
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk({e.tag, "_valid"}, 64'(got), 64'd1);
        chk({e.tag, "_lat"}, 64'(lat + 1), 64'(lat_exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({e.tag, "_holdv"}, 64'(rsp_valid), 64'd1);
            chk({e.tag, "_holdr"}, 64'(req_ready), 64'd0);
            chk({e.tag, "_holdd"}, rsp_result, e.res);
        end
        rsp_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            g = exp_q.pop_front();
            chk({g.tag, "_res"}, rsp_result, g.res);
            chk({g.tag, "_tkn"}, 64'(rsp_taken), 64'(g.taken));
            chk({g.tag, "_ovf"}, 64'(rsp_overflow), 64'(g.ovf));
`ifdef ALU_ERR_EN
            chk({g.tag, "_err"}, 64'(rsp_error), 64'(g.err));
`endif
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({e.tag, "_dropv"}, 64'(rsp_valid), 64'd0);
        chk({e.tag, "_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_rdy", 64'(req_ready), 64'd1);
        chk("rst_vld", 64'(rsp_valid), 64'd0);
        chk("rst_res", rsp_result, 64'd0);
        chk("rst_tkn", 64'(rsp_taken), 64'd0);
        chk("rst_ovf", 64'(rsp_overflow), 64'd0);
        chk("rst_fn", 64'(alu_funct), 64'd0);
        chk("rst_a", alu_a, 64'd0);
`ifdef ALU_ERR_EN
        chk("rst_err", 64'(rsp_error), 64'd0);
`endif

        mk("add", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, e);
        do_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              2, 1, 9'd1, 0, e);

        mk("or", 64'hFFF0, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd4, 64'hF0F0, 64'h0FF0,
              4, 3, {3'd4, 3'd4, 3'd3}, 0, e);

        mk("blt", 64'd0, 1'b1, 1'b0, 1'b0, e);
        do_op(4'd8, -64'sd5, 64'd3, 2, 1, 9'd2, 0, e);

        mk("bge", 64'd0, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd9, -64'sd5, 64'd3, 2, 1, 9'd2, 0, e);

        mk("slt", 64'd0, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd5, 64'd3, 64'd3, 2, 1, 9'd2, 0, e);

        mk("beq", 64'd0, 1'b1, 1'b0, 1'b0, e);
        do_op(4'd6, 64'd3, 64'd3, 2, 1, 9'd2, 0, e);

        mk("slt1", 64'd1, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd5, -64'sd1, 64'd0, 2, 1, 9'd2, 0, e);

        mk("bne", 64'd0, 1'b1, 1'b0, 1'b0, e);
        do_op(4'd7, 64'd4, 64'd3, 2, 1, 9'd2, 0, e);

        mk("sub", 64'd7, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd1, 64'd10, 64'd3, 2, 1, 9'd2, 5, e);

        mk("not", 64'hFFFF_FFFF_FFFF_00FF, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd10, 64'hFF00, 64'h1234, 2, 1, 9'd5, 0, e);

        mk("inc", 64'd0, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9,
              2, 1, 9'd6, 0, e);

        mk("mov", 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd12, 64'hDEAD_BEEF, 64'h55, 2, 1, 9'd0, 0, e);

        mk("and", 64'h0F00, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd2, 64'hFF00, 64'h0FF0, 2, 1, 9'd3, 0, e);

        mk("xor", 64'hF0F0, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd3, 64'hFF00, 64'h0FF0, 2, 1, 9'd4, 0, e);

        mk("ill", 64'd0, 1'b0, 1'b0, 1'b1, e);
        do_op(4'd14, 64'h1234, 64'h5678, 2, 1, 9'd0, 0, e);

        // Abort an OR in its second pass with reset.
        req_op    = 4'd4;
        req_a     = 64'hF0F0;
        req_b     = 64'h0FF0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_p2", 64'(alu_funct), 64'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_rdy", 64'(req_ready), 64'd1);
        chk("abort_vld", 64'(rsp_valid), 64'd0);
        chk("abort_res", rsp_result, 64'd0);
        chk("abort_a", alu_a, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_norsp", 64'(seen), 64'd0);

        mk("add2", 64'd5, 1'b0, 1'b0, 1'b0, e);
        do_op(4'd0, 64'd2, 64'd3, 2, 1, 9'd1, 0, e);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle issuing controller that sits on the operation side of the 64-bit ALU. It drives `funct` and the operands, and consumes `result` and the status flags.
- It accepts one RV64 ALU/branch request via a valid/ready handshake and sequences one or more ALU passes. Ops with no native ALU funct (OR) take three passes; SLT and the branch conditions are derived from the ALU flags.
- It returns a registered response via a valid/ready handshake to the execute stage.

Parameters:
- XLEN, 64, operand/result width (must match ALU width).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request
- req_op  in  4  op code (see package)
- req_a  in  XLEN  operand A
- req_b  in  XLEN  operand B
- alu_funct  out  3  ALU funct: LOAD=0 SUM=1 SUB=2 AND=3 XOR=4 NOT=5 INC=6
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B
- alu_result  in  XLEN  ALU result (combinational, same cycle)
- alu_overflow  in  1  ALU overflow flag
- alu_equal  in  1  ALU a==b
- alu_less  in  1  ALU signed a<b
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  XLEN  operation result
- rsp_taken  out  1  branch condition true
- rsp_overflow  out  1  signed overflow (ADD/SUB only)
- rsp_error  out  1  only with ALU_ERR_EN

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=1, rsp_valid=0, rsp_result=0, rsp_taken=0, rsp_overflow=0, rsp_error=0.
  - Internal op/a/b/tmp registers 0.
- States: IDLE, P1, P2, P3, RESP.
- req_ready is 1 only in IDLE. Accept when req_valid&&req_ready: latch op, a, b; go to P1.
- ALU drive is combinational from state and latched regs.
  - IDLE/RESP: funct=LOAD, alu_a=a_q, alu_b=b_q.
- Single-pass ops, P1 then RESP; result captured at the P1 clock edge:
  - ADD: funct SUM, result=alu_result, overflow=alu_overflow.
  - SUB: funct SUB, result=alu_result, overflow=alu_overflow.
  - AND: funct AND. XOR: funct XOR. NOT: funct NOT on a. INC: funct INC on a. MOV: funct LOAD.
  - SLT: funct SUB, result={63'b0,alu_less}.
  - BEQ: funct SUB, taken=equal. BNE: taken=~equal. BLT: taken=less. BGE: taken=~less.
  - All branches: result=0.
- OR takes three passes:
  - P1: AND(a,b) -> tmp.
  - P2: XOR(a,b) -> res_q.
  - P3: XOR(res_q,tmp) -> result.
  - Then RESP.
- Illegal op (13..15): no ALU pass; go directly to P1 with funct LOAD and capture result=0, taken=0.
- rsp_taken=0 for non-branch ops; rsp_overflow=0 for everything except ADD/SUB.
- Latency (accept edge = cycle 0):
  - rsp_valid high from cycle 2 for single-pass ops; from cycle 4 for OR.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE and deassert rsp_valid next cycle.
  - No new acceptance until IDLE (non-pipelined); back-to-back throughput is 1 op per 3 cycles minimum.
- Reset mid-operation: the sequence is abandoned, no response is emitted, and all outputs return to reset values on the next edge.
- Arithmetic: all XLEN-bit, wrap-around. Flags come from the ALU and are not recomputed.

Optional Feature:
- Macro: ALU_ERR_EN.
- Defined:
  - rsp_error port exists.
  - Set in RESP for an illegal op, or for ADD/SUB with alu_overflow=1.
  - Reset value 0; cleared for other ops.
- Undefined: rsp_error port absent; illegal ops silently return 0.

Decomposition:
- Shared package alu_pkg:
  - alu_funct_t: 3-bit enum matching ALU encoding LOAD..INC.
  - alu_op_t: 4-bit request ops ADD=0 SUB=1 AND=2 XOR=3 OR=4 SLT=5 BEQ=6 BNE=7 BLT=8 BGE=9 NOT=10 INC=11 MOV=12.
  - ctrl_state_t.
- Natural sub-module: alu_op_map, a combinational op+state -> funct/operand-select/pass-count table.
- Top instantiates the FSM and registers; the ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> rsp_result=0x8000_0000_0000_0000, rsp_overflow=1, rsp_valid at cycle 2.
- OR a=0xF0F0, b=0x0FF0 -> three ALU passes (funct AND, XOR, XOR) -> rsp_result=0xFFF0 at cycle 4.
- BLT a=-5, b=3 -> rsp_taken=1, rsp_result=0. BGE with the same operands -> rsp_taken=0.
- SLT a=3, b=3 -> rsp_result=0. Then BEQ with the same operands -> rsp_taken=1.
- Backpressure: rsp_ready=0 for 5 cycles after SUB 10-3 -> rsp_result=7 held stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
- reset asserted in P2 of OR -> no rsp_valid; req_ready=1 after the reset edge. req_op=14 with ALU_ERR_EN -> rsp_result=0, rsp_error=1.
